// File: rtl/pio_in_pkg.sv
// Shared register map and edge-select encodings for the interrupt-capable input PIO.
package pio_in_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_debounce.sv
// Per-bit debouncer sharing one sample-tick counter; a level must match on three
// consecutive ticks before it is accepted. DEBOUNCE_CYCLES=0 turns it into a wire.
module pio_in_debounce #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign dout           = din;
  end else begin : g_filter
    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic [WIDTH-1:0] hist0_q, hist0_d;
    logic [WIDTH-1:0] hist1_q, hist1_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] stable;

    // NOTE: every comb output gets a default before any conditional update, so no latches.
    always_comb begin
      tick    = (cnt_q == CNT_LAST);
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      stable  = ~(din ^ hist0_q) & ~(hist0_q ^ hist1_q);
      hist0_d = hist0_q;
      hist1_d = hist1_q;
      deb_d   = deb_q;
      if (tick) begin
        hist0_d = din;
        hist1_d = hist0_q;
        deb_d   = (deb_q & ~stable) | (din & stable);
      end
    end

    // NOTE: state flops use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        hist0_q <= '0;
        hist1_q <= '0;
        deb_q   <= '0;
      end else begin
        cnt_q   <= cnt_d;
        hist0_q <= hist0_d;
        hist1_q <= hist1_d;
        deb_q   <= deb_d;
      end
    end

    assign dout = deb_q;
  end

endmodule

// File: rtl/pio_in_irq.sv
// Avalon-MM input PIO: synchroniser, optional debouncer, edge capture with
// per-bit mask and a registered level interrupt.
module pio_in_irq
  import pio_in_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;
  logic [31:0]      rd_q, rd_d;
  logic [WIDTH-1:0] rise, fall, edge_hit, w1c;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  pio_in_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (sync_q[SYNC_STAGES-1]),
    .dout   (deb)
  );

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
    data_d = deb;
    prev_d = data_q;

    rise = data_q & ~prev_q;
    fall = ~data_q & prev_q;
    if (EDGE_TYPE == EDGE_RISE)      edge_hit = rise;
    else if (EDGE_TYPE == EDGE_FALL) edge_hit = fall;
    else                             edge_hit = rise | fall;

    wr_en  = chipselect & ~write_n;
    mask_d = (wr_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
    w1c    = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    // A new edge wins over a same-cycle clear so no event is lost.
    cap_d  = (cap_q & ~w1c) | edge_hit;
    irq_d  = |(cap_q & mask_q);

    case (reg_addr_e'(address))
      ADDR_DATA: rd_d = 32'(data_q);
      ADDR_MASK: rd_d = 32'(mask_q);
      ADDR_EDGE: rd_d = 32'(cap_q);
      default:   rd_d = '0;
    endcase
  end

  // NOTE: synchroniser flops are reset too, so the power-up input value is a clean 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      data_q <= '0;
      prev_q <= '0;
      cap_q  <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      sync_q <= sync_d;
      data_q <= data_d;
      prev_q <= prev_d;
      cap_q  <= cap_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
      rd_q   <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_irq.sv
// Self-checking bench: four PIO configurations share one bus and one input vector,
// each compared against a behavioural model built from sample logs and tick histories.
module tb_pio_in_irq;

  localparam int W = 4;
  localparam int N = 4;
  localparam int SYNC [N] = '{2, 2, 3, 2};
  localparam int DEB  [N] = '{0, 4, 0, 0};
  localparam int EDG  [N] = '{0, 0, 2, 1};

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [1:0]     address = '0;
  logic           chipselect = 1'b0;
  logic           write_n = 1'b1;
  logic [31:0]    writedata = '0;
  logic [W-1:0]   in_port = '0;
  logic [31:0]    rd [N];
  logic           irq_o [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pio_in_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[0]), .irq(irq_o[0]));

  pio_in_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_deb (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[1]), .irq(irq_o[1]));

  pio_in_irq #(.WIDTH(W), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[2]), .irq(irq_o[2]));

  pio_in_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[3]), .irq(irq_o[3]));

  // ---------------- behavioural reference model ----------------
  logic [W-1:0] in_log [$];   // in_port value seen at each clock edge since reset
  logic [W-1:0] tick_s [$];   // synced values seen at debounce ticks (two reset zeros first)
  logic [W-1:0] deb_lvl;
  logic [W-1:0] m_data [N], m_prev [N], m_cap [N], m_mask [N];
  logic         m_irq [N];
  logic [31:0]  m_rd [N];
  logic [W-1:0] dv [N];
  logic [W-1:0] hit, w1c;
  int           t, n;
  logic         wr;

  function automatic logic [W-1:0] synced(int i, int edges);
    if (edges >= SYNC[i]) return in_log[edges - SYNC[i]];
    return '0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_log.delete();
      tick_s.delete();
      tick_s.push_back('0);
      tick_s.push_back('0);
      deb_lvl = '0;
      for (int i = 0; i < N; i++) begin
        m_data[i] = '0; m_prev[i] = '0; m_cap[i] = '0; m_mask[i] = '0;
        m_irq[i] = 1'b0; m_rd[i] = '0;
      end
    end else begin
      t = in_log.size();
      for (int i = 0; i < N; i++) dv[i] = (DEB[i] == 0) ? synced(i, t) : deb_lvl;
      if ((t + 1) % DEB[1] == 0) begin
        tick_s.push_back(synced(1, t));
        n = tick_s.size();
        for (int b = 0; b < W; b++)
          if (tick_s[n-1][b] == tick_s[n-2][b] && tick_s[n-2][b] == tick_s[n-3][b])
            deb_lvl[b] = tick_s[n-1][b];
      end
      in_log.push_back(in_port);
      wr  = chipselect && !write_n;
      w1c = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int i = 0; i < N; i++) begin
        case (address)
          2'd0:    m_rd[i] = {28'd0, m_data[i]};
          2'd2:    m_rd[i] = {28'd0, m_mask[i]};
          2'd3:    m_rd[i] = {28'd0, m_cap[i]};
          default: m_rd[i] = '0;
        endcase
        m_irq[i] = |(m_cap[i] & m_mask[i]);
        if (EDG[i] == 0)      hit = m_data[i] & ~m_prev[i];
        else if (EDG[i] == 1) hit = ~m_data[i] & m_prev[i];
        else                  hit = m_data[i] ^ m_prev[i];
        m_cap[i] = (m_cap[i] & ~w1c) | hit;
        if (wr && address == 2'd2) m_mask[i] = writedata[W-1:0];
        m_prev[i] = m_data[i];
        m_data[i] = dv[i];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle(int k = 1);
    repeat (k) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr_reg(logic [1:0] a, logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_n = 1'b0; in_port = 4'hA; address = 2'd0;
    cycle(3);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rd[i] !== 32'd0 || irq_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold inst%0d: readdata=%h irq=%b, expected 0/0", i, rd[i], irq_o[i]);
      end
    end
    reset_n = 1'b1;
    cycle(4);
    checks++;
    if (rd[0] !== 32'h0000000A) begin
      errors++;
      $display("FAIL data_latency: readdata=%h, expected 0000000a", rd[0]);
    end
    address = 2'd1;
    cycle();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rd[i] !== 32'd0) begin
        errors++;
        $display("FAIL rsvd_read inst%0d: readdata=%h, expected 0", i, rd[i]);
      end
    end
    wr_reg(2'd1, 32'hFFFF_FFFF);
    wr_reg(2'd0, 32'hFFFF_FFFF);
    address = 2'd2;
    cycle(2);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rd[i] !== m_rd[i]) begin
        errors++;
        $display("FAIL ignored_write inst%0d: readdata=%h, expected %h", i, rd[i], m_rd[i]);
      end
    end
  endtask

  task automatic test_rise_irq;
    in_port = '0;
    cycle(20);
    wr_reg(2'd3, 32'hF);
    wr_reg(2'd2, 32'h1);
    address = 2'd3;
    cycle(2);
    in_port[0] = 1'b1;
    cycle(4);
    checks++;
    if (irq_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: irq=%b, expected 0", irq_o[0]);
    end
    cycle();
    checks++;
    if (irq_o[0] !== 1'b1 || rd[0] !== 32'h1) begin
      errors++;
      $display("FAIL irq_latency: irq=%b cap=%h, expected 1/00000001", irq_o[0], rd[0]);
    end
    wr_reg(2'd3, 32'h1);
    cycle();
    checks++;
    if (irq_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: irq=%b, expected 0", irq_o[0]);
    end
    for (int k = 0; k < 6; k++) begin
      in_port[1] = ~in_port[1];
      cycle(3);
      checks++;
      if (irq_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL masked_bit step%0d: irq=%b, expected 0", k, irq_o[0]);
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rd[i] !== m_rd[i] || irq_o[i] !== m_irq[i]) begin
        errors++;
        $display("FAIL rise_model inst%0d: readdata=%h irq=%b, expected %h/%b",
                 i, rd[i], irq_o[i], m_rd[i], m_irq[i]);
      end
    end
  endtask

  task automatic test_set_wins;
    wr_reg(2'd2, 32'h4);
    wr_reg(2'd3, 32'hF);
    address = 2'd3;
    cycle(2);
    in_port[2] = 1'b1;
    cycle(3);
    wr_reg(2'd3, 32'h4);
    cycle();
    checks++;
    if (irq_o[0] !== 1'b1 || rd[0][2] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: irq=%b cap=%h, expected irq 1 and cap bit2 1", irq_o[0], rd[0]);
    end
    cycle();
    checks++;
    if (irq_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins_hold: irq=%b, expected 1", irq_o[0]);
    end
  endtask

  task automatic test_debounce;
    cycle(20);
    wr_reg(2'd3, 32'hF);
    address = 2'd0;
    in_port[1] = 1'b1;
    cycle(3);
    in_port[1] = 1'b0;
    cycle(20);
    checks++;
    if (rd[1][1] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_data: data=%h, expected bit1 0", rd[1]);
    end
    address = 2'd3;
    cycle();
    checks++;
    if (rd[1][1] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_cap: cap=%h, expected bit1 0", rd[1]);
    end
    address = 2'd0;
    in_port[1] = 1'b1;
    cycle(20);
    checks++;
    if (rd[1][1] !== 1'b1) begin
      errors++;
      $display("FAIL level_data: data=%h, expected bit1 1", rd[1]);
    end
    address = 2'd3;
    cycle();
    checks++;
    if (rd[1][1] !== 1'b1) begin
      errors++;
      $display("FAIL level_cap: cap=%h, expected bit1 1", rd[1]);
    end
  endtask

  task automatic test_edge_types;
    in_port[3] = 1'b1;
    cycle(10);
    wr_reg(2'd3, 32'hF);
    address = 2'd3;
    cycle(2);
    in_port[3] = 1'b0;
    cycle(6);
    checks++;
    if (rd[2][3] !== 1'b1 || rd[3][3] !== 1'b1) begin
      errors++;
      $display("FAIL fall_edge: any_cap=%h fall_cap=%h, expected bit3 1/1", rd[2], rd[3]);
    end
    wr_reg(2'd3, 32'hF);
    cycle(2);
    in_port[3] = 1'b1;
    cycle(6);
    checks++;
    if (rd[2][3] !== 1'b1 || rd[3][3] !== 1'b0) begin
      errors++;
      $display("FAIL rise_edge: any_cap=%h fall_cap=%h, expected bit3 1/0", rd[2], rd[3]);
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(15) == 0) in_port = 4'($urandom);
      address    = 2'($urandom);
      chipselect = 1'($urandom_range(1));
      write_n    = 1'($urandom_range(1));
      writedata  = $urandom;
      cycle();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (rd[i] !== m_rd[i] || irq_o[i] !== m_irq[i]) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: readdata=%h irq=%b, expected %h/%b",
                   i, c, rd[i], irq_o[i], m_rd[i], m_irq[i]);
        end
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset_mid;
    in_port = '0;
    cycle(24);
    wr_reg(2'd2, 32'hF);
    wr_reg(2'd3, 32'hF);
    address = 2'd3;
    cycle(2);
    in_port = 4'hF;
    cycle(6);
    checks++;
    if (irq_o[0] !== 1'b1 || rd[0] !== 32'hF) begin
      errors++;
      $display("FAIL pre_reset: irq=%b cap=%h, expected 1/0000000f", irq_o[0], rd[0]);
    end
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rd[i] !== 32'd0 || irq_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset inst%0d: readdata=%h irq=%b, expected 0/0", i, rd[i], irq_o[i]);
      end
    end
    in_port = '0;
    cycle(2);
    reset_n = 1'b1;
    address = 2'd2;
    cycle(10);
    checks++;
    if (rd[0] !== 32'd0) begin
      errors++;
      $display("FAIL mask_after_reset: mask=%h, expected 0", rd[0]);
    end
    address = 2'd3;
    cycle();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rd[i] !== 32'd0 || irq_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL cap_after_reset inst%0d: cap=%h irq=%b, expected 0/0", i, rd[i], irq_o[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise_irq();
    test_set_wins();
    test_debounce();
    test_edge_types();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_in_irq.md
Name: pio_in_irq

Overview:
- Parametrised Avalon-MM input PIO; successor to the fixed 2-bit, read-only, polled input port.
- Adds a configurable width, an input synchroniser, and an optional per-bit debouncer.
- Adds edge capture with per-bit interrupt mask and a level IRQ to the processor.
- Sits between board-level inputs (push buttons, switches, sensor flags) and the SOPC interconnect.

Parameters:
- WIDTH, 2, input port width, 1..32.
- SYNC_STAGES, 2, synchroniser flops per bit, 2..4.
- DEBOUNCE_CYCLES, 50000, clk cycles between debounce sample ticks; 0 bypasses the debouncer.
- EDGE_TYPE, 0, edge detected: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset; one clock domain
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data
- irq  out  1  registered interrupt request, level, active-high

Behaviour:
- Reset (async assert, sync release via clk): all of the following are 0:
  - synchroniser flops, debouncer state, tick counter
  - data_reg, edge_capture, irq_mask
  - readdata, irq
- Register map, upper 32-WIDTH bits read as 0:
  - addr 0 DATA (RO): debounced input value.
  - addr 1 reserved: reads 0, writes ignored.
  - addr 2 IRQ_MASK (RW): bit i enables edge_capture[i] onto irq.
  - addr 3 EDGE_CAP (RW1C): writing 1 to a bit clears it; writing 0 leaves it unchanged.
- Write occurs when chipselect=1 and write_n=0 at a rising edge of clk.
- readdata is re-registered every clock from the address mux, independent of any read strobe. Latency is 1 cycle from address to readdata.
- Synchroniser: SYNC_STAGES flops per bit; sync output lags in_port by SYNC_STAGES clocks.
- Debouncer (DEBOUNCE_CYCLES>0):
  - A shared counter counts 0..DEBOUNCE_CYCLES-1 and emits a one-cycle tick at wrap.
  - Each bit keeps a 2-deep sample history, shifted on tick.
  - When the current synced value equals both history samples at a tick, the debounced bit takes that value; otherwise it holds.
  - Net effect: a level must be seen on 3 consecutive ticks to be accepted.
  - Glitches shorter than one tick period never reach the debounced output.
- Bypass (DEBOUNCE_CYCLES=0): debounced = synced, no counter logic.
- data_reg is the debounced vector. deb_prev is its one-cycle-delayed copy.
- Edge detect per bit:
  - rise = data_reg & ~deb_prev
  - fall = ~data_reg & deb_prev
  - selected by EDGE_TYPE
- edge_capture[i] is set on the clock after the edge. Set has priority over a same-cycle W1C clear of that bit.
- irq is registered: irq <= |(edge_capture & irq_mask). It asserts 1 clock after the capture bit sets or the mask bit is written, and deasserts 1 clock after clear.
- Bypass latency, in_port 0→1 to irq=1: SYNC_STAGES + 3 clocks, when the mask is already set.
- An input held at 1 through reset release produces a rising edge once it has propagated: the power-up state is 0.
- Reset mid-debounce: counter and history cleared. Debounce restarts from 0 on release.
- Writes to DATA and reserved addresses have no effect.

Decomposition:
- Package pio_in_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3
  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings
- One sub-module, pio_in_debounce:
  - parameters WIDTH, DEBOUNCE_CYCLES
  - contains the shared tick counter and per-bit history/accept logic
  - generates a pass-through when DEBOUNCE_CYCLES=0
- The top level holds the synchroniser, edge detect, registers, read mux and irq.

Test Plan:
1. Reset value and read latency (WIDTH=4, DEBOUNCE_CYCLES=0): hold reset_n=0, in_port=4'hA -> readdata=0 and irq=0 during reset. After release, address=0 -> readdata=32'h0000000A within SYNC_STAGES+2 clocks; address=1 -> 0 next clock.
2. Rising edge IRQ with bypass: write MASK=4'h1, pulse in_port[0] 0→1 -> EDGE_CAP reads 4'h1 and irq=1 at SYNC_STAGES+3 clocks. Write 32'h1 to EDGE_CAP -> irq=0 the next clock. Masked bit 1 toggling never raises irq.
3. Set-wins collision: time a W1C write of bit 2 to land in the same clock the edge on bit 2 is captured -> EDGE_CAP[2] stays 1 and irq stays high.
4. Debounce filter (DEBOUNCE_CYCLES=4): a 3-clock pulse on in_port[1] -> DATA[1] stays 0, no capture. A level held for 16 clocks -> DATA[1]=1 after the 3rd matching tick, EDGE_CAP[1]=1.
5. EDGE_TYPE=2 on any edge: 1→0 and 0→1 on bit 3 each set EDGE_CAP[3]. EDGE_TYPE=1 captures only 1→0.
6. Reset mid-operation: assert reset_n=0 with EDGE_CAP=4'hF, MASK=4'hF and irq=1 -> irq, readdata, EDGE_CAP and MASK are 0 immediately (asynchronous assertion) and stay 0 after release until a new edge.
